// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4-input mux between 4 requesters.
// Optional grant timeout enabled by defining ARB_TIMEOUT_EN.
module mux4_rr_arbiter #(
    parameter int N_REQ    = 4,
    parameter int HOLD_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [1:0]       select,
    output logic             busy,
    output logic             timeout
);

    if (N_REQ != 4) begin : g_bad_nreq
        $error("N_REQ must be 4");
    end
    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
        $error("HOLD_MAX must be in 1..255");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] select_q, select_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;

    logic [1:0] next_ptr;
    logic [1:0] win_idle;
    logic [1:0] win_rel;
    logic       rel_normal;
    logic       force_rel;

    // First requester at or after p, wrapping modulo 4.
    function automatic logic [1:0] rr_pick(
        input logic [3:0] r,
        input logic [1:0] p
    );
        logic [1:0] idx;
        logic       found;
        rr_pick = p;
        found   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = p + k[1:0];
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign next_ptr   = select_q + 2'd1;
    assign win_idle   = rr_pick(req, rr_ptr_q);
    assign win_rel    = rr_pick(req, next_ptr);
    assign rel_normal = done || !req[select_q];

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX - 1);

    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       timeout_q, timeout_d;

    assign force_rel = (state_q == GRANT)
                    && !rel_normal
                    && (hold_cnt_q == HOLD_LIM);

    // Hold counter: clears on any release, counts grant cycles otherwise.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        if (state_q == GRANT) begin
            if (rel_normal) begin
                hold_cnt_d = 8'd0;
            end else if (force_rel) begin
                hold_cnt_d = 8'd0;
                timeout_d  = 1'b1;
            end else begin
                hold_cnt_d = hold_cnt_q + 8'd1;
            end
        end
    end

    // Counter and timeout pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

    // Next state: grant from idle, or release with back-to-back regrant.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        select_d = select_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d  = GRANT;
                    gnt_d    = 4'b0001 << win_idle;
                    select_d = win_idle;
                end
            end
            GRANT: begin
                if (rel_normal || force_rel) begin
                    rr_ptr_d = next_ptr;
                    if (|req) begin
                        gnt_d    = 4'b0001 << win_rel;
                        select_d = win_rel;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= 4'b0000;
            select_q <= 2'd0;
            rr_ptr_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            select_q <= select_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign gnt    = gnt_q;
    assign select = select_q;
    assign busy   = (state_q == GRANT);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter.
// Directed scenarios followed by random traffic against a reference model.
module tb_mux4_rr_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int HM = 4;
`else
    localparam int HM = 15;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic [3:0] gnt;
    logic [1:0] select;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    // Reference model: current owner (-1 when idle), priority start,
    // last select value, cycles held, timeout pulse.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_sel   = 0;
    int m_cnt   = 0;
    int m_to    = 0;
    int stepno  = 0;

    mux4_rr_arbiter #(
        .N_REQ   (4),
        .HOLD_MAX(HM)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .done   (done),
        .gnt    (gnt),
        .select (select),
        .busy   (busy),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step %0d: observed %0h expected %0h",
                   tag, stepno, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_sel   = 0;
        m_cnt   = 0;
        m_to    = 0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic d);
        int  w;
        bit  rel;
        bit  frc;
        m_to = 0;
        if (m_owner < 0) begin
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_sel   = w;
                m_cnt   = 0;
            end
        end else begin
            rel = d || !r[m_owner];
            frc = 0;
`ifdef ARB_TIMEOUT_EN
            frc = !rel && (m_cnt == HM - 1);
`endif
            if (rel || frc) begin
                m_to  = frc ? 1 : 0;
                m_ptr = (m_owner + 1) % 4;
                m_cnt = 0;
                w     = pick(r, m_ptr);
                if (w >= 0) begin
                    m_owner = w;
                    m_sel   = w;
                end else begin
                    m_owner = -1;
                end
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic compare_all();
        logic [3:0] eg;
        eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        chk("gnt", 32'(gnt), 32'(eg));
        chk("select", 32'(select), 32'(m_sel));
        chk("busy", 32'(busy), (m_owner >= 0) ? 32'd1 : 32'd0);
        chk("timeout", 32'(timeout), 32'(m_to));
    endtask

    task automatic step(input logic [3:0] r, input logic d);
        @(negedge clk);
        req  = r;
        done = d;
        model_step(r, d);
        @(posedge clk);
        #1;
        stepno++;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    int exp_seq [5] = '{0, 1, 2, 3, 0};

    initial begin
        // Reset values
        #2;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_sel", 32'(select), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_to", 32'(timeout), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Async reset mid-grant, then 1-cycle grant latency
        step(4'b0010, 1'b0);
        chk("pre_rst_gnt", 32'(gnt), 32'b0010);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_gnt", 32'(gnt), 32'd0);
        chk("async_sel", 32'(select), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        model_reset();
        req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        step(4'b1000, 1'b0);
        chk("after_rst_gnt", 32'(gnt), 32'b1000);
        chk("after_rst_sel", 32'(select), 32'd3);
        step(4'b0000, 1'b1);

        // Round-robin with all requesting
        do_reset();
        step(4'b1111, 1'b0);
        chk("rr_sel0", 32'(select), 32'(exp_seq[0]));
        for (int j = 1; j < 5; j++) begin
            step(4'b1111, 1'b0);
            step(4'b1111, 1'b0);
            step(4'b1111, 1'b1);
            chk("rr_sel", 32'(select), 32'(exp_seq[j]));
            chk("rr_nogap", 32'(busy), 32'd1);
        end
        step(4'b0000, 1'b1);

        // Priority wrap
        do_reset();
        step(4'b1000, 1'b0);
        step(4'b1001, 1'b1);
        chk("wrap_gnt0", 32'(gnt), 32'b0001);
        step(4'b1001, 1'b1);
        chk("wrap_gnt3", 32'(gnt), 32'b1000);

        // Abandon and done-while-idle
        step(4'b0000, 1'b1);
        step(4'b0100, 1'b0);
        chk("ab_gnt", 32'(gnt), 32'b0100);
        step(4'b0000, 1'b0);
        chk("ab_rel", 32'(gnt), 32'd0);
        step(4'b0000, 1'b1);
        chk("idle_done_gnt", 32'(gnt), 32'd0);
        chk("idle_done_sel", 32'(select), 32'd2);

        // No preemption
        step(4'b0001, 1'b0);
        chk("np_gnt", 32'(gnt), 32'b0001);
        step(4'b0011, 1'b0);
        step(4'b0011, 1'b0);
        chk("np_hold", 32'(gnt), 32'b0001);
        step(4'b0011, 1'b1);
        chk("np_next", 32'(gnt), 32'b0010);
        step(4'b0000, 1'b1);

`ifdef ARB_TIMEOUT_EN
        // Forced release after HOLD_MAX cycles
        do_reset();
        step(4'b0100, 1'b0);
        for (int j = 0; j < 3; j++) begin
            step(4'b0100, 1'b0);
            chk("to_hold", 32'(gnt), 32'b0100);
            chk("to_quiet", 32'(timeout), 32'd0);
        end
        step(4'b0100, 1'b0);
        chk("to_pulse", 32'(timeout), 32'd1);
        chk("to_regnt", 32'(gnt), 32'b0100);
        for (int j = 0; j < 3; j++) step(4'b0100, 1'b0);
        step(4'b0100, 1'b1);
        chk("to_done_wins", 32'(timeout), 32'd0);
        step(4'b0000, 1'b1);
`endif

        // Random traffic
        do_reset();
        for (int j = 0; j < 400; j++) begin
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
